// File: rtl/march_bist_controller_pkg.sv
// Shared definitions for the March C- BIST sequencer: FSM states, element
// indices and the per-element configuration record.
package march_bist_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RD,
        S_CMP,
        S_WR,
        S_DONE
    } state_t;

    localparam int NUM_ELEMS = 6;
    localparam int ELEM_W    = 3;

    typedef logic [ELEM_W-1:0] elem_idx_t;

    localparam elem_idx_t ELEM_E0   = 3'd0;
    localparam elem_idx_t ELEM_E1   = 3'd1;
    localparam elem_idx_t ELEM_E2   = 3'd2;
    localparam elem_idx_t ELEM_E3   = 3'd3;
    localparam elem_idx_t ELEM_E4   = 3'd4;
    localparam elem_idx_t ELEM_E5   = 3'd5;
    localparam elem_idx_t LAST_ELEM = ELEM_E5;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One march element: direction, which ops it performs, the background
    // expected on reads and the background written.
    typedef struct packed {
        logic dir;
        logic has_rd;
        logic has_wr;
        logic exp_bit;
        logic wr_bit;
    } elem_cfg_t;

    // E0 up(w0)
    localparam elem_cfg_t E0_CFG = '{dir: DIR_UP,   has_rd: 1'b0, has_wr: 1'b1, exp_bit: 1'b0, wr_bit: 1'b0};
    // E1 up(r0,w1)
    localparam elem_cfg_t E1_CFG = '{dir: DIR_UP,   has_rd: 1'b1, has_wr: 1'b1, exp_bit: 1'b0, wr_bit: 1'b1};
    // E2 up(r1,w0)
    localparam elem_cfg_t E2_CFG = '{dir: DIR_UP,   has_rd: 1'b1, has_wr: 1'b1, exp_bit: 1'b1, wr_bit: 1'b0};
    // E3 down(r0,w1)
    localparam elem_cfg_t E3_CFG = '{dir: DIR_DOWN, has_rd: 1'b1, has_wr: 1'b1, exp_bit: 1'b0, wr_bit: 1'b1};
    // E4 down(r1,w0)
    localparam elem_cfg_t E4_CFG = '{dir: DIR_DOWN, has_rd: 1'b1, has_wr: 1'b1, exp_bit: 1'b1, wr_bit: 1'b0};
    // E5 up(r0)
    localparam elem_cfg_t E5_CFG = '{dir: DIR_UP,   has_rd: 1'b1, has_wr: 1'b0, exp_bit: 1'b0, wr_bit: 1'b0};

endpackage

// File: rtl/march_bist_controller_element_rom.sv
// Combinational lookup of the March C- element table.
module march_element_rom
    import march_bist_controller_pkg::*;
(
    input  elem_idx_t i_elem,
    output elem_cfg_t o_cfg
);

    // Decode the element index into its direction/op/background record.
    always_comb begin
        // NOTE: default first so unlisted indices cannot infer a latch.
        o_cfg = '0;
        case (i_elem)
            ELEM_E0: o_cfg = E0_CFG;
            ELEM_E1: o_cfg = E1_CFG;
            ELEM_E2: o_cfg = E2_CFG;
            ELEM_E3: o_cfg = E3_CFG;
            ELEM_E4: o_cfg = E4_CFG;
            ELEM_E5: o_cfg = E5_CFG;
            default: o_cfg = '0;
        endcase
    end

endmodule

// File: rtl/march_bist_controller.sv
// March C- memory-BIST sequencer. Drives an external address generator and
// the memory under test, compares read data against the element background
// and reports done/fail plus the first failing address.
module march_bist_controller
    import march_bist_controller_pkg::*;
#(
    parameter int AD_W         = 4,
    parameter int D_W          = 8,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [AD_W-1:0] fail_addr,
    output logic            ag_reset,
    output logic            ag_preset,
    output logic            ag_en,
    output logic            ag_up_down,
    input  logic            ag_carry,
    input  logic [AD_W-1:0] ag_address,
    output logic            mem_we,
    output logic            mem_re,
    output logic [D_W-1:0]  mem_wdata,
    input  logic [D_W-1:0]  mem_rdata
);

    state_t          r_state;
    elem_idx_t       r_elem;
    logic            r_last_q;
    logic            r_fail;
    logic [AD_W-1:0] r_fail_addr;

    elem_cfg_t       w_cfg;
    logic            w_last_op;
    logic            w_is_last;
    logic            w_step;
    logic            w_mismatch;
    state_t          w_adv_state;
    elem_idx_t       w_adv_elem;

    march_element_rom u_rom (
        .i_elem (r_elem),
        .o_cfg  (w_cfg)
    );

    // The last op of an address is WR, or CMP for a read-only element.
    assign w_last_op  = (r_state == S_WR) || ((r_state == S_CMP) && !w_cfg.has_wr);
    // Carry is a one-cycle pulse at the start of the final address; last_q holds it.
    assign w_is_last  = ag_carry | r_last_q;
    assign w_step     = w_last_op && !w_is_last;
    assign w_mismatch = (mem_rdata != {D_W{w_cfg.exp_bit}});

    // Where to go once the final address of an element has been handled.
    assign w_adv_state = (r_elem == LAST_ELEM) ? S_DONE : S_INIT;
    assign w_adv_elem  = (r_elem == LAST_ELEM) ? r_elem : elem_idx_t'(r_elem + elem_idx_t'(1));

    // Sequencer FSM, final-address flag and sticky fail capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_elem      <= ELEM_E0;
            r_last_q    <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
        end else begin
            // NOTE: non-blocking throughout, so later assignments in this
            // block (e.g. INIT clearing last_q) override earlier ones cleanly.
            if (w_step) begin
                r_last_q <= 1'b0;
            end else if (ag_carry && busy) begin
                r_last_q <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fail      <= 1'b0;
                        r_fail_addr <= '0;
                        r_elem      <= ELEM_E0;
                        r_state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_last_q <= 1'b0;
                    r_state  <= w_cfg.has_rd ? S_RD : S_WR;
                end
                S_RD: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    if (w_mismatch) begin
                        r_fail <= 1'b1;
                        if (!r_fail) begin
                            r_fail_addr <= ag_address;
                        end
                    end
                    if (w_mismatch && STOP_ON_FAIL) begin
                        r_state <= S_DONE;
                    end else if (w_cfg.has_wr) begin
                        r_state <= S_WR;
                    end else if (w_is_last) begin
                        r_state <= w_adv_state;
                        r_elem  <= w_adv_elem;
                    end else begin
                        r_state <= S_RD;
                    end
                end
                S_WR: begin
                    if (w_is_last) begin
                        r_state <= w_adv_state;
                        r_elem  <= w_adv_elem;
                    end else begin
                        r_state <= w_cfg.has_rd ? S_RD : S_WR;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decodes of state/element; direction is driven only while busy
    // so IDLE/DONE present all-zero outputs.
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign fail       = r_fail;
    assign fail_addr  = r_fail_addr;
    assign ag_reset   = (r_state == S_INIT) && (w_cfg.dir == DIR_UP);
    assign ag_preset  = (r_state == S_INIT) && (w_cfg.dir == DIR_DOWN);
    assign ag_en      = w_step;
    assign ag_up_down = busy && w_cfg.dir;
    assign mem_re     = (r_state == S_RD);
    assign mem_we     = (r_state == S_WR);
    assign mem_wdata  = (r_state == S_WR) ? {D_W{w_cfg.wr_bit}} : '0;

endmodule

// File: tb/tb_march_bist_controller.sv
// Directed bench: three controllers (AD_W=4, AD_W=4 with STOP_ON_FAIL,
// AD_W=1), each with an address-generator model and a 1-cycle-read RAM.
module tb_march_bist_controller;

    logic       clk;
    logic       reset_n;
    logic [2:0] start_v;
    int         errors;
    int         checks;

    // ---------------- instance A: AD_W=4, D_W=8, no stop ----------------
    logic       a_busy, a_done, a_fail;
    logic [3:0] a_fail_addr;
    logic       a_ag_reset, a_ag_preset, a_ag_en, a_ag_up_down, a_ag_carry;
    logic [3:0] a_ag_address;
    logic       a_mem_we, a_mem_re;
    logic [7:0] a_mem_wdata, a_mem_rdata;
    logic [7:0] a_mem [16];
    logic       a_fault, a_rd_pend;
    logic [3:0] a_wr_addr_q[$];
    logic [7:0] a_wr_data_q[$];
    logic [3:0] a_rd_addr_q[$];
    logic [7:0] a_rd_data_q[$];

    // ---------------- instance B: AD_W=4, D_W=8, stop on fail ----------------
    logic       b_busy, b_done, b_fail;
    logic [3:0] b_fail_addr;
    logic       b_ag_reset, b_ag_preset, b_ag_en, b_ag_up_down, b_ag_carry;
    logic [3:0] b_ag_address;
    logic       b_mem_we, b_mem_re;
    logic [7:0] b_mem_wdata, b_mem_rdata;
    logic [7:0] b_mem [16];
    int         b_wr_cnt, b_rd_cnt;

    // ---------------- instance C: AD_W=1, D_W=8 ----------------
    logic       c_busy, c_done, c_fail;
    logic [0:0] c_fail_addr;
    logic       c_ag_reset, c_ag_preset, c_ag_en, c_ag_up_down, c_ag_carry;
    logic [0:0] c_ag_address;
    logic       c_mem_we, c_mem_re;
    logic [7:0] c_mem_wdata, c_mem_rdata;
    logic [7:0] c_mem [2];
    logic [0:0] c_wr_addr_q[$];
    logic [0:0] c_rd_addr_q[$];

    wire [2:0]  done_v = {c_done, b_done, a_done};
    wire [20:0] a_outs = {a_busy, a_done, a_fail, a_fail_addr, a_ag_reset, a_ag_preset, a_ag_en,
                          a_ag_up_down, a_mem_we, a_mem_re, a_mem_wdata};
    wire [20:0] b_outs = {b_busy, b_done, b_fail, b_fail_addr, b_ag_reset, b_ag_preset, b_ag_en,
                          b_ag_up_down, b_mem_we, b_mem_re, b_mem_wdata};
    wire [17:0] c_outs = {c_busy, c_done, c_fail, c_fail_addr, c_ag_reset, c_ag_preset, c_ag_en,
                          c_ag_up_down, c_mem_we, c_mem_re, c_mem_wdata};

    march_bist_controller #(.AD_W(4), .D_W(8), .STOP_ON_FAIL(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]),
        .busy(a_busy), .done(a_done), .fail(a_fail), .fail_addr(a_fail_addr),
        .ag_reset(a_ag_reset), .ag_preset(a_ag_preset), .ag_en(a_ag_en), .ag_up_down(a_ag_up_down),
        .ag_carry(a_ag_carry), .ag_address(a_ag_address),
        .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    march_bist_controller #(.AD_W(4), .D_W(8), .STOP_ON_FAIL(1'b1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]),
        .busy(b_busy), .done(b_done), .fail(b_fail), .fail_addr(b_fail_addr),
        .ag_reset(b_ag_reset), .ag_preset(b_ag_preset), .ag_en(b_ag_en), .ag_up_down(b_ag_up_down),
        .ag_carry(b_ag_carry), .ag_address(b_ag_address),
        .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    march_bist_controller #(.AD_W(1), .D_W(8), .STOP_ON_FAIL(1'b0)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]),
        .busy(c_busy), .done(c_done), .fail(c_fail), .fail_addr(c_fail_addr),
        .ag_reset(c_ag_reset), .ag_preset(c_ag_preset), .ag_en(c_ag_en), .ag_up_down(c_ag_up_down),
        .ag_carry(c_ag_carry), .ag_address(c_ag_address),
        .mem_we(c_mem_we), .mem_re(c_mem_re), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address generator models: sync reset/preset, count on en, carry pulses
    // in the cycle after the step that lands on the terminal address.
    initial begin
        a_ag_address = '0; a_ag_carry = 1'b0;
        b_ag_address = '0; b_ag_carry = 1'b0;
        c_ag_address = '0; c_ag_carry = 1'b0;
        a_rd_pend = 1'b0;
        b_wr_cnt = 0; b_rd_cnt = 0;
    end

    always @(posedge clk) begin
        if (a_ag_reset) begin a_ag_address <= 4'h0; a_ag_carry <= 1'b0; end
        else if (a_ag_preset) begin a_ag_address <= 4'hF; a_ag_carry <= 1'b0; end
        else if (a_ag_en) begin
            if (a_ag_up_down) begin a_ag_address <= a_ag_address + 4'h1; a_ag_carry <= (a_ag_address == 4'hE); end
            else begin a_ag_address <= a_ag_address - 4'h1; a_ag_carry <= (a_ag_address == 4'h1); end
        end else a_ag_carry <= 1'b0;
    end

    always @(posedge clk) begin
        if (b_ag_reset) begin b_ag_address <= 4'h0; b_ag_carry <= 1'b0; end
        else if (b_ag_preset) begin b_ag_address <= 4'hF; b_ag_carry <= 1'b0; end
        else if (b_ag_en) begin
            if (b_ag_up_down) begin b_ag_address <= b_ag_address + 4'h1; b_ag_carry <= (b_ag_address == 4'hE); end
            else begin b_ag_address <= b_ag_address - 4'h1; b_ag_carry <= (b_ag_address == 4'h1); end
        end else b_ag_carry <= 1'b0;
    end

    always @(posedge clk) begin
        if (c_ag_reset) begin c_ag_address <= 1'b0; c_ag_carry <= 1'b0; end
        else if (c_ag_preset) begin c_ag_address <= 1'b1; c_ag_carry <= 1'b0; end
        else if (c_ag_en) begin
            if (c_ag_up_down) begin c_ag_address <= c_ag_address + 1'b1; c_ag_carry <= (c_ag_address == 1'b0); end
            else begin c_ag_address <= c_ag_address - 1'b1; c_ag_carry <= (c_ag_address == 1'b1); end
        end else c_ag_carry <= 1'b0;
    end

    // RAM models with 1-cycle read latency plus access loggers. A and B can
    // inject stuck-at-0 on bit 3 of address 5 (read path).
    always @(posedge clk) begin
        if (a_mem_we) begin
            a_mem[a_ag_address] <= a_mem_wdata;
            a_wr_addr_q.push_back(a_ag_address);
            a_wr_data_q.push_back(a_mem_wdata);
        end
        if (a_mem_re) begin
            a_mem_rdata <= (a_fault && a_ag_address == 4'd5) ? (a_mem[a_ag_address] & 8'hF7) : a_mem[a_ag_address];
            a_rd_addr_q.push_back(a_ag_address);
        end
        if (a_rd_pend) a_rd_data_q.push_back(a_mem_rdata);
        a_rd_pend <= a_mem_re;
    end

    always @(posedge clk) begin
        if (b_mem_we) begin
            b_mem[b_ag_address] <= b_mem_wdata;
            b_wr_cnt <= b_wr_cnt + 1;
        end
        if (b_mem_re) begin
            b_mem_rdata <= (b_ag_address == 4'd5) ? (b_mem[b_ag_address] & 8'hF7) : b_mem[b_ag_address];
            b_rd_cnt <= b_rd_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (c_mem_we) begin
            c_mem[c_ag_address] <= c_mem_wdata;
            c_wr_addr_q.push_back(c_ag_address);
        end
        if (c_mem_re) begin
            c_mem_rdata <= c_mem[c_ag_address];
            c_rd_addr_q.push_back(c_ag_address);
        end
    end

    // Wait (bounded) until the selected instance shows done; cyc counts edges
    // after the start-sampling edge, or 1000 on timeout.
    task automatic wait_done(input int which, output int cyc);
        cyc = 0;
        while (cyc < 1000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_v[which]) break;
        end
    endtask

    task automatic run_to_done(input int which, input bit hold, output int cyc);
        @(negedge clk);
        a_wr_addr_q.delete(); a_wr_data_q.delete(); a_rd_addr_q.delete(); a_rd_data_q.delete();
        c_wr_addr_q.delete(); c_rd_addr_q.delete();
        b_wr_cnt = 0; b_rd_cnt = 0;
        start_v[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_v[which] = 1'b0;
        wait_done(which, cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_outs !== 21'h0) begin errors++; $display("FAIL reset_a: outputs=%h required=0", a_outs); end
        checks++; if (b_outs !== 21'h0) begin errors++; $display("FAIL reset_b: outputs=%h required=0", b_outs); end
        checks++; if (c_outs !== 18'h0) begin errors++; $display("FAIL reset_c: outputs=%h required=0", c_outs); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b required=0", a_busy); end
    endtask

    task automatic test_fault_free();
        int cyc;
        int nbad;
        a_fault = 1'b0;
        run_to_done(0, 1'b0, cyc);
        checks++; if (cyc !== 246) begin errors++; $display("FAIL ff_latency: done at %0d required 246", cyc); end
        checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL ff_fail: fail=%b required=0", a_fail); end
        checks++; if (a_wr_addr_q.size() !== 80 || a_rd_addr_q.size() !== 80) begin
            errors++; $display("FAIL ff_counts: writes=%0d reads=%0d required 80/80", a_wr_addr_q.size(), a_rd_addr_q.size());
        end
        nbad = 0;
        for (int i = 0; i < 80 && i < a_wr_addr_q.size(); i++) begin
            int blk;
            logic [3:0] ea;
            logic [7:0] ed;
            blk = i / 16;
            ea = (blk == 3 || blk == 4) ? 4'(15 - (i % 16)) : 4'(i % 16);
            ed = (blk % 2 == 1) ? 8'hFF : 8'h00;
            if (a_wr_addr_q[i] !== ea || a_wr_data_q[i] !== ed) nbad++;
        end
        checks++; if (nbad !== 0) begin errors++; $display("FAIL ff_wr_seq: bad entries=%0d required 0", nbad); end
        nbad = 0;
        for (int i = 0; i < 80 && i < a_rd_addr_q.size(); i++) begin
            int blk;
            logic [3:0] ea;
            blk = i / 16;
            ea = (blk == 2 || blk == 3) ? 4'(15 - (i % 16)) : 4'(i % 16);
            if (a_rd_addr_q[i] !== ea) nbad++;
        end
        checks++; if (nbad !== 0) begin errors++; $display("FAIL ff_rd_addr_seq: bad entries=%0d required 0", nbad); end
        checks++; if (a_rd_addr_q.size() > 47 && (a_rd_addr_q[32] !== 4'd15 || a_rd_addr_q[47] !== 4'd0)) begin
            errors++; $display("FAIL ff_e3_range: first=%0d last=%0d required 15/0", a_rd_addr_q[32], a_rd_addr_q[47]);
        end
        @(negedge clk);
        checks++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL ff_done_pulse: done=%b busy=%b required 0/0", a_done, a_busy);
        end
    endtask

    task automatic test_stuck_at();
        int cyc;
        int first_idx;
        logic [7:0] first_val;
        a_fault = 1'b1;
        run_to_done(0, 1'b0, cyc);
        checks++; if (cyc !== 246) begin errors++; $display("FAIL sa_latency: done at %0d required 246", cyc); end
        checks++; if (a_fail !== 1'b1 || a_fail_addr !== 4'd5) begin
            errors++; $display("FAIL sa_fail: fail=%b addr=%0d required 1/5", a_fail, a_fail_addr);
        end
        first_idx = -1;
        first_val = 8'h00;
        for (int i = 0; i < a_rd_data_q.size(); i++) begin
            logic [7:0] ed;
            ed = ((i / 16) % 2 == 1) ? 8'hFF : 8'h00;
            if (first_idx < 0 && a_rd_data_q[i] !== ed) begin
                first_idx = i;
                first_val = a_rd_data_q[i];
            end
        end
        checks++; if (first_idx !== 21 || first_val !== 8'hF7) begin
            errors++; $display("FAIL sa_first_mismatch: read index=%0d value=%h required 21/f7", first_idx, first_val);
        end
        a_fault = 1'b0;
    endtask

    task automatic test_stop_on_fail();
        int cyc;
        run_to_done(1, 1'b0, cyc);
        checks++; if (cyc !== 84) begin errors++; $display("FAIL sof_latency: done at %0d required 84", cyc); end
        checks++; if (b_fail !== 1'b1 || b_fail_addr !== 4'd5) begin
            errors++; $display("FAIL sof_fail: fail=%b addr=%0d required 1/5", b_fail, b_fail_addr);
        end
        repeat (10) @(negedge clk);
        checks++; if (b_wr_cnt !== 37 || b_rd_cnt !== 22) begin
            errors++; $display("FAIL sof_strobes: writes=%0d reads=%0d required 37/22", b_wr_cnt, b_rd_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        a_fault = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (130) @(negedge clk);
        checks++; if (a_fail !== 1'b1 || a_busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre: fail=%b busy=%b required 1/1", a_fail, a_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (a_outs !== 21'h0) begin errors++; $display("FAIL rst_async: outputs=%h required=0", a_outs); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        a_fault = 1'b0;
        run_to_done(0, 1'b0, cyc);
        checks++; if (cyc !== 246 || a_fail !== 1'b0) begin
            errors++; $display("FAIL rst_rerun: done at %0d fail=%b required 246/0", cyc, a_fail);
        end
        checks++; if (a_wr_addr_q.size() !== 80 || a_rd_addr_q.size() !== 80) begin
            errors++; $display("FAIL rst_rerun_counts: writes=%0d reads=%0d required 80/80", a_wr_addr_q.size(), a_rd_addr_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        int done_at;
        ndone = 0;
        done_at = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            start_v[0] = (c == 50 || c == 150);
        end
        checks++; if (ndone !== 1 || done_at !== 246) begin
            errors++; $display("FAIL busy_start: dones=%0d first at %0d required 1 at 246", ndone, done_at);
        end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: busy=%b required 0", a_busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        a_fault = 1'b1;
        run_to_done(0, 1'b1, cyc);
        checks++; if (cyc !== 246 || a_fail !== 1'b1) begin
            errors++; $display("FAIL b2b_first: done at %0d fail=%b required 246/1", cyc, a_fail);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_fail !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: busy=%b fail=%b required 0/1", a_busy, a_fail);
        end
        a_fault = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_busy !== 1'b1 || a_fail !== 1'b0) begin
            errors++; $display("FAIL b2b_restart: busy=%b fail=%b required 1/0", a_busy, a_fail);
        end
        start_v[0] = 1'b0;
        wait_done(0, cyc);
        checks++; if (cyc !== 246 || a_fail !== 1'b0) begin
            errors++; $display("FAIL b2b_second: done at %0d fail=%b required 246/0", cyc, a_fail);
        end
    endtask

    task automatic test_two_word();
        int cyc;
        int nbad;
        logic [0:9] ew;
        logic [0:9] er;
        ew = 10'b0101011010;
        er = 10'b0101101001;
        run_to_done(2, 1'b0, cyc);
        checks++; if (cyc !== 36) begin errors++; $display("FAIL tw_latency: done at %0d required 36", cyc); end
        checks++; if (c_fail !== 1'b0) begin errors++; $display("FAIL tw_fail: fail=%b required 0", c_fail); end
        nbad = (c_wr_addr_q.size() == 10 && c_rd_addr_q.size() == 10) ? 0 : 100;
        for (int i = 0; i < 10 && i < c_wr_addr_q.size(); i++) if (c_wr_addr_q[i] !== ew[i]) nbad++;
        for (int i = 0; i < 10 && i < c_rd_addr_q.size(); i++) if (c_rd_addr_q[i] !== er[i]) nbad++;
        checks++; if (nbad !== 0) begin
            errors++; $display("FAIL tw_addr_seq: bad=%0d writes=%0d reads=%0d required 0/10/10", nbad, c_wr_addr_q.size(), c_rd_addr_q.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start_v = 3'b000;
        a_fault = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_stop_on_fail();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        test_two_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
